apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_if.sv | 26 ++
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and default bus widths.
// Used by apb_master and by the APB responder.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_state_e;

endpackage : apb_pkg

// File: rtl/apb_if.sv
// APB bus bundle.
//   requester : drives psel, penable, pwrite, paddr, pwdata; samples pready, prdata, pslverr
//   completer : the mirror image
interface apb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport requester (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport completer (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface : apb_if

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and reports completion as a one-cycle rsp_valid pulse, with an optional
// ACCESS-phase timeout.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = state is IDLE)
//   cmd_write/addr/wdata       command payload, captured on accept
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata/err/timeout      completion status, held until the next completion
//   apb                        APB requester port
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = APB_ADDR_W,
   parameter int unsigned DATA_W  = APB_DATA_W,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   apb_if.requester          apb
);

   // Counter is kept at least one bit wide so TIMEOUT = 0 still elaborates.
   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
   localparam bit TMO_EN = (TIMEOUT != 0);

   apb_mst_state_e   state;
   apb_mst_state_e   state_nx;
   logic [CNT_W-1:0] tmo_cnt;
   logic             xfer_done;
   logic             xfer_tmo;

   // Ready is a pure decode of the state register.
   assign cmd_ready = (state == IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; pready wins over an expiring timeout.
   always_comb begin
      state_nx  = state;
      xfer_done = 1'b0;
      xfer_tmo  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nx = SETUP;
            end
         end
         SETUP: begin
            state_nx = ACCESS;
         end
         ACCESS: begin
            if (apb.pready) begin
               state_nx  = IDLE;
               xfer_done = 1'b1;
            end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
               state_nx  = IDLE;
               xfer_tmo  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // APB strobes registered from the next state so pready never reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
      end else begin
         apb.psel    <= (state_nx != IDLE);
         apb.penable <= (state_nx == ACCESS);
      end
   end

   // Command capture; held untouched until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apb.pwrite <= 1'b0;
         apb.paddr  <= '0;
         apb.pwdata <= '0;
      end else if (cmd_ready && cmd_valid) begin
         apb.pwrite <= cmd_write;
         apb.paddr  <= cmd_addr;
         apb.pwdata <= cmd_wdata;
      end
   end

   // ACCESS wait counter: cleared in SETUP, advances on each stalled ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == SETUP) begin
         tmo_cnt <= '0;
      end else if ((state == ACCESS) && !apb.pready && TMO_EN) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // Response: valid pulses, status fields hold until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= xfer_done || xfer_tmo;
         if (xfer_done) begin
            rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
            rsp_err     <= apb.pslverr;
            rsp_timeout <= 1'b0;
         end else if (xfer_tmo) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a configurable APB responder model.
module tb_apb_master;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 4;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          acc;
      logic [31:0] addr;
      logic        wr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;

   apb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .apb         (apb)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
   endtask

   // Responder model: pready after resp_wait stalled ACCESS cycles, never if resp_hang.
   int          resp_wait  = 1;
   logic        resp_hang  = 1'b0;
   logic        resp_err   = 1'b0;
   logic [31:0] resp_rdata = '0;
   int          acc_cnt    = 0;

   always @(posedge clk)
      acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;

   always_comb begin
      apb.pready  = apb.psel && apb.penable && !resp_hang && (acc_cnt == resp_wait);
      apb.pslverr = apb.pready && resp_err;
      apb.prdata  = resp_rdata;
   end

   // Cycle counter and accept log.
   int cyc   = 0;
   int n_acc = 0;
   int acc_cyc[$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) begin
         n_acc <= n_acc + 1;
         acc_cyc.push_back(cyc);
      end
   end

   // Monitor: tracks the bus window and checks each response against the scoreboard.
   exp_t        exp_q[$];
   int          n_rsp    = 0;
   bit          in_xfer  = 0;
   bit          stable   = 1;
   int          mon_acc  = 0;
   logic [31:0] cap_addr = '0;
   logic        cap_wr   = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_xfer = 0;
      end else begin
         if (apb.psel) begin
            if (!in_xfer) begin
               in_xfer  = 1;
               stable   = 1;
               mon_acc  = 0;
               cap_addr = apb.paddr;
               cap_wr   = apb.pwrite;
            end else if (apb.paddr !== cap_addr || apb.pwrite !== cap_wr) begin
               stable = 0;
            end
            if (apb.penable) mon_acc++;
         end
         if (rsp_valid) begin
            exp_t e;
            n_rsp++;
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
               chk("rsp_err",     64'(rsp_err),     64'(e.err));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
               chk("access_cycles", 64'(mon_acc),   64'(e.acc));
               chk("paddr",       64'(cap_addr),    64'(e.addr));
               chk("pwrite",      64'(cap_wr),      64'(e.wr));
               chk("bus_stable",  64'(stable),      64'(1));
               chk("psel_dropped", 64'(apb.psel),   64'(0));
               chk("cmd_ready_at_rsp", 64'(cmd_ready), 64'(1));
            end
            in_xfer = 0;
         end
      end
   end

   function automatic exp_t mk(input logic [31:0] rd, input logic er, input logic tm,
                               input int ac, input logic [31:0] ad, input logic wr);
      exp_t e;
      e.rdata = rd; e.err = er; e.tmo = tm; e.acc = ac; e.addr = ad; e.wr = wr;
      return e;
   endfunction

   // Issue one command and wait (bounded) for its accept; scramble cmd_* afterwards.
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit push, input exp_t e);
      int n0;
      n0 = n_acc;
      if (push) exp_q.push_back(e);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && n_acc == n0; i++) begin
         @(posedge clk); #1;
      end
      chk("accept", 64'(n_acc - n0), 64'(1));
      cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
      chk("wait_rsp", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int n0;
      exp_t none;
      none = mk(32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);

      // Reset values.
      #12;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_psel",      64'(apb.psel), 64'(0));
      chk("rst_penable",   64'(apb.penable), 64'(0));
      chk("rst_paddr",     64'(apb.paddr), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Write, one wait state: 2 ACCESS cycles.
      resp_wait = 1; resp_hang = 0; resp_err = 0; resp_rdata = 32'h1111_2222;
      send(1'b1, 32'h10, 32'hA5A5_0001, 1, mk(32'h0, 1'b0, 1'b0, 2, 32'h10, 1'b1));
      wait_rsp();

      // Read, one wait state.
      resp_rdata = 32'hDEAD_BEEF;
      send(1'b0, 32'h20, 32'h0, 1, mk(32'hDEAD_BEEF, 1'b0, 1'b0, 2, 32'h20, 1'b0));
      wait_rsp();

      // Timeout: 4 stalled ACCESS cycles.
      resp_hang = 1;
      send(1'b0, 32'h30, 32'h0, 1, mk(32'h0, 1'b1, 1'b1, 4, 32'h30, 1'b0));
      wait_rsp();
      resp_hang = 0;

      // Slave error, zero wait states.
      resp_wait = 0; resp_err = 1; resp_rdata = 32'h1234_5678;
      send(1'b0, 32'h40, 32'h0, 1, mk(32'h1234_5678, 1'b1, 1'b0, 1, 32'h40, 1'b0));
      wait_rsp();

      // pready on the 4th ACCESS cycle beats the timeout.
      resp_wait = 3; resp_err = 0; resp_rdata = 32'hCAFE_0003;
      send(1'b0, 32'h44, 32'h0, 1, mk(32'hCAFE_0003, 1'b0, 1'b0, 4, 32'h44, 1'b0));
      wait_rsp();
      repeat (5) @(posedge clk);
      #1;
      chk("hold_rdata", 64'(rsp_rdata), 64'(32'hCAFE_0003));
      chk("hold_err",   64'(rsp_err),   64'(0));

      // Back-to-back writes with cmd_valid held high.
      resp_wait = 0;
      acc_cyc.delete();
      n0 = n_acc;
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1, 32'h100, 1'b1));
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1, 32'h104, 1'b1));
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1, 32'h108, 1'b1));
      cmd_write = 1'b1; cmd_wdata = 32'h0B0B_0000; cmd_addr = 32'h100; cmd_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         for (int i = 0; i < 20 && n_acc < n0 + k; i++) begin
            @(posedge clk); #1;
         end
         cmd_addr  = 32'h100 + 32'(4 * k);
         cmd_wdata = 32'h0B0B_0000 + 32'(k);
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", 64'(n_acc - n0), 64'(3));
      wait_rsp();
      chk("b2b_gap1", 64'((acc_cyc.size() == 3) ? acc_cyc[1] - acc_cyc[0] : -1), 64'(3));
      chk("b2b_gap2", 64'((acc_cyc.size() == 3) ? acc_cyc[2] - acc_cyc[1] : -1), 64'(3));

      // Reset during ACCESS aborts silently.
      resp_hang = 1;
      send(1'b1, 32'h200, 32'h5555_AAAA, 0, none);
      for (int i = 0; i < 10 && !apb.penable; i++) @(negedge clk);
      chk("pre_rst_penable", 64'(apb.penable), 64'(1));
      n0 = n_rsp;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_psel",    64'(apb.psel), 64'(0));
      chk("rst_mid_penable", 64'(apb.penable), 64'(0));
      resp_hang = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_no_rsp", 64'(n_rsp - n0), 64'(0));
      chk("post_rst_psel",   64'(apb.psel), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_apb_master
